// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
// Serial transmitter half of the UART. Bytes arrive through a valid/ready
// handshake into a one-entry holding register and are serialised on tx_po as
// asynchronous frames: start bit, LSB-first data, optional parity, stop bit(s).
// Queuing a byte while the current frame is on the line gives back-to-back
// frames with no idle gap.
//
// Ports:
//   clk_10MHz    in   system clock, all logic on its rising edge
//   rst          in   synchronous active-high reset
//   tx_data_pi   in   byte to transmit, sampled on acceptance
//   tx_start_pi  in   request valid, accepted only while tx_ready_po=1
//   tx_ready_po  out  holding register empty
//   tx_busy_po   out  frame on the line or byte pending
//   tx_done_po   out  one-cycle pulse as a frame's last stop bit completes
//   tx_po        out  serial line (registered), idles high
// ---------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk_10MHz,
  input  logic       rst,
  input  logic [7:0] tx_data_pi,
  input  logic       tx_start_pi,
  output logic       tx_ready_po,
  output logic       tx_busy_po,
  output logic       tx_done_po,
  output logic       tx_po
);

  // Wide enough for STOP_BITS*CLKS_PER_BIT - 1 at the largest legal setting.
  localparam int unsigned CNT_W = 17;
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             end_q, end_d;      // last stop-bit cycle just finished
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             line_s;
  logic             xfer_s;
  logic             accept_s;
  logic             cnt_zero_s;

  assign accept_s   = tx_start_pi & ~hold_full_q;
  assign cnt_zero_s = (cnt_q == CNT_ZERO);

  // Frame sequencer: next state, bit timing, shift/hold transfer and line level.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    xfer_s  = 1'b0;
    end_d   = 1'b0;
    line_s  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        line_s = 1'b1;
        if (hold_full_q) begin
          xfer_s  = 1'b1;
          shift_d = hold_q;
          cnt_d   = BIT_LOAD;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        line_s = 1'b0;
        if (cnt_zero_s) begin
          cnt_d   = BIT_LOAD;
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        line_s = shift_q[idx_q];
        if (cnt_zero_s) begin
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
            cnt_d   = PARITY_EN ? BIT_LOAD : STOP_LOAD;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = BIT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_PARITY: begin
        line_s = parity_bit(shift_q, PARITY_ODD);
        if (cnt_zero_s) begin
          cnt_d   = STOP_LOAD;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        line_s = 1'b1;
        if (cnt_zero_s) begin
          end_d = 1'b1;
          if (hold_full_q) begin
            // Chain straight into the next start bit: no idle gap.
            xfer_s  = 1'b1;
            shift_d = hold_q;
            cnt_d   = BIT_LOAD;
            state_d = ST_START;
          end else begin
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Holding register and registered status/line outputs.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept_s) begin
      // A new byte may land in the same edge the old one leaves.
      hold_d      = tx_data_pi;
      hold_full_d = 1'b1;
    end else if (xfer_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end
    // The line and done pulse lag the sequencer by one register stage, so
    // busy includes end_d to stay high until the done pulse appears.
    tx_d    = line_s;
    done_d  = end_q;
    ready_d = ~hold_full_d;
    busy_d  = hold_full_d | (state_d != ST_IDLE) | end_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_10MHz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      cnt_q       <= CNT_ZERO;
      idx_q       <= 3'd0;
      tx_q        <= 1'b1;
      end_q       <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      end_q       <= end_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_po       = tx_q;
  assign tx_done_po  = done_q;
  assign tx_ready_po = ready_q;
  assign tx_busy_po  = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
`timescale 1ns/1ps
module tb_uart_tx_framer;

  localparam int ND   = 4;
  localparam int MAXF = 256;

  // Per-instance configuration mirrored by the reference model.
  int c_cfg    [ND] = '{87, 4, 4, 4};
  int par_cfg  [ND] = '{0, 1, 1, 0};
  int odd_cfg  [ND] = '{0, 0, 1, 0};
  int stop_cfg [ND] = '{1, 1, 1, 2};

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] start_v;
  logic [7:0]    data_v [ND];
  logic [ND-1:0] tx_v, ready_v, busy_v, done_v;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: every accepted byte becomes a frame with its accept edge,
  // first start-bit cycle and byte value.
  int         f_t0 [ND][MAXF];
  int         f_st [ND][MAXF];
  logic [7:0] f_b  [ND][MAXF];
  int         nf   [ND];

  always #50 clk = ~clk;

  uart_tx_framer u0 (
    .clk_10MHz(clk), .rst(rst), .tx_data_pi(data_v[0]), .tx_start_pi(start_v[0]),
    .tx_ready_po(ready_v[0]), .tx_busy_po(busy_v[0]), .tx_done_po(done_v[0]), .tx_po(tx_v[0]));

  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u1 (
    .clk_10MHz(clk), .rst(rst), .tx_data_pi(data_v[1]), .tx_start_pi(start_v[1]),
    .tx_ready_po(ready_v[1]), .tx_busy_po(busy_v[1]), .tx_done_po(done_v[1]), .tx_po(tx_v[1]));

  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u2 (
    .clk_10MHz(clk), .rst(rst), .tx_data_pi(data_v[2]), .tx_start_pi(start_v[2]),
    .tx_ready_po(ready_v[2]), .tx_busy_po(busy_v[2]), .tx_done_po(done_v[2]), .tx_po(tx_v[2]));

  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u3 (
    .clk_10MHz(clk), .rst(rst), .tx_data_pi(data_v[3]), .tx_start_pi(start_v[3]),
    .tx_ready_po(ready_v[3]), .tx_busy_po(busy_v[3]), .tx_done_po(done_v[3]), .tx_po(tx_v[3]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_cycles(input int d);
    return (1 + 8 + par_cfg[d] + stop_cfg[d]) * c_cfg[d];
  endfunction

  function automatic logic exp_tx(input int d, input int c);
    logic [7:0] b;
    int k;
    for (int i = 0; i < nf[d]; i++) begin
      if (c >= f_st[d][i] && c < f_st[d][i] + frame_cycles(d)) begin
        b = f_b[d][i];
        k = (c - f_st[d][i]) / c_cfg[d];
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (par_cfg[d] != 0 && k == 9) return (^b) ^ (odd_cfg[d] != 0);
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_done(input int d, input int c);
    for (int i = 0; i < nf[d]; i++)
      if (c == f_st[d][i] + frame_cycles(d)) return 1'b1;
    return 1'b0;
  endfunction

  // Holding register is full from the accept edge until the edge before the start bit.
  function automatic logic exp_ready(input int d, input int c);
    for (int i = 0; i < nf[d]; i++)
      if (c >= f_t0[d][i] && c < f_st[d][i] - 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int d, input int c);
    for (int i = 0; i < nf[d]; i++)
      if (c >= f_t0[d][i] && c < f_st[d][i] + frame_cycles(d)) return 1'b1;
    return 1'b0;
  endfunction

  // Record a frame accepted at the coming edge (cyc+1); its start bit is on
  // the line two edges later, or when the previous frame ends.
  task automatic record(input int d, input logic [7:0] b);
    int t0, st, prev_end;
    t0 = cyc + 1;
    st = t0 + 2;
    if (nf[d] > 0) begin
      prev_end = f_st[d][nf[d]-1] + frame_cycles(d);
      if (prev_end > st) st = prev_end;
    end
    f_t0[d][nf[d]] = t0;
    f_st[d][nf[d]] = st;
    f_b[d][nf[d]]  = b;
    nf[d]++;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) for (int d = 0; d < ND; d++) nf[d] = 0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("u%0d_tx@%0d", d, cyc),    tx_v[d],    exp_tx(d, cyc));
      check_eq($sformatf("u%0d_done@%0d", d, cyc),  done_v[d],  exp_done(d, cyc));
      check_eq($sformatf("u%0d_ready@%0d", d, cyc), ready_v[d], exp_ready(d, cyc));
      check_eq($sformatf("u%0d_busy@%0d", d, cyc),  busy_v[d],  exp_busy(d, cyc));
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // One-cycle request; the model records it only if the DUT should accept it.
  task automatic send(input int d, input logic [7:0] b);
    start_v[d] = 1'b1;
    data_v[d]  = b;
    if (!rst && exp_ready(d, cyc) && nf[d] < MAXF) record(d, b);
    step();
    start_v[d] = 1'b0;
    data_v[d]  = 8'($urandom);
  endtask

  task automatic wait_ready(input int d, input string tag);
    int n;
    n = 0;
    while (ready_v[d] !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) check_eq(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    logic s;
    for (int d = 0; d < ND; d++) begin
      nf[d] = 0;
      data_v[d] = 8'h5A;
    end
    // Reset held for 3 cycles with start requests pending.
    rst = 1'b1;
    start_v = '1;
    run(3);
    rst = 1'b0;
    start_v = '0;
    run(20);

    // Single byte on the default instance.
    send(0, 8'hAA);
    run(900);

    // Back to back: second byte queued as soon as ready returns.
    send(0, 8'h8C);
    wait_ready(0, "bb_ready_timeout");
    send(0, 8'h3F);
    run(1800);

    // Parity and two-stop-bit instances.
    send(1, 8'h07);
    run(50);
    send(2, 8'h07);
    run(50);
    send(3, 8'h00);
    run(50);
    send(1, 8'hFF);
    send(2, 8'hFF);
    send(3, 8'hFF);
    run(60);

    // Random traffic on all instances; data changes every cycle.
    repeat (4000) begin
      for (int d = 0; d < ND; d++) begin
        s = ($urandom_range(7, 0) == 0) && (nf[d] < MAXF - 1);
        start_v[d] = s;
        data_v[d]  = 8'($urandom);
        if (s && exp_ready(d, cyc)) record(d, data_v[d]);
      end
      step();
    end
    start_v = '0;
    run(2000);

    // Reset during data bit 3 with a second byte pending.
    send(0, 8'hAA);
    target = f_st[0][nf[0]-1] + 4 * c_cfg[0] + 40;
    wait_ready(0, "rm_ready_timeout");
    send(0, 8'h55);
    while (cyc < target) step();
    rst = 1'b1;
    step();
    check_eq("rst_mid_tx", tx_v[0], 1'b1);
    check_eq("rst_mid_ready", ready_v[0], 1'b1);
    rst = 1'b0;
    run(1900);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
